opc_intc: RTL
=============

Name: opc_intc

Overview:
- Memory-mapped, prioritised interrupt controller for the OPC5LS CPU.
- Collects up to NSRC peripheral interrupt lines; per-source mask and edge/level mode.
- Drives the CPU's single active-low int_b input.
- Sits on the CPU bus (address, dout, rnw) as a slave; its read data is muxed into the CPU's din by the top level, using sel.

Parameters:
- NSRC, 8: number of interrupt sources, 1..16; source 0 is highest priority.
- BASE_ADDR, 16'hFE00: base word address; must be 8-word aligned.

Ports:
- clk, input, 1: system clock, same as CPU.
- reset_b, input, 1: asynchronous, active-low reset.
- address, input, 16: CPU word address.
- wdata, input, 16: CPU dout.
- rnw, input, 1: CPU read-not-write; 0 = write this cycle.
- irq_src, input, NSRC: asynchronous interrupt requests, active high.
- rdata, output, 16: register read data, combinational.
- sel, output, 1: high when address is in this block's 8-word window.
- int_b, output, 1: registered interrupt request to CPU, active low.

Behaviour:
- Decode: sel = (address[15:3] == BASE_ADDR[15:3]); offset = address[2:0].
- rdata = 0 when sel is low.
- Write: on posedge clk when sel & !rnw. The CPU holds a write for exactly one cycle (WRMEM), so no strobe or handshake. Reads have no side effects.
- Register map, bits [NSRC-1:0] used, upper bits read 0:
  - 0 STATUS, RO: pending & mask.
  - 1 MASK, RW: 1 = enabled. Reset 0.
  - 2 PENDING: read returns raw pending. Write-1-to-clear, edge-mode bits only; W1C on level bits is ignored.
  - 3 MODE, RW: 1 = edge (rising), 0 = level. Reset 0.
  - 4 VECTOR, RO: index of the lowest-numbered set STATUS bit, as 16'h000i; 16'hFFFF when none.
  - 5..7: read 0; writes ignored.
- Synchroniser: irq_src passes through a 2-flop synchroniser (s1, s2); a third flop s3 holds the previous s2 value for edge detect. All reset to 0.
- Pending update, per bit, each clock:
  - Level mode: pending <= s2.
  - Edge mode: pending <= (s2 & !s3) | (pending & !clr), where clr is a W1C write hitting this bit. A new edge in the same cycle as the clear wins: pending stays 1.
- Mode change (MODE write): takes effect next cycle.
  - Level→edge: current pending value is retained.
  - Edge→level: pending follows s2 from the next cycle.
- int_b <= !(|(pending & mask)), registered. Reset value 1.
- Latency, from the first clock edge at which irq_src is sampled high (edge k):
  - s1 at k, s2 at k+1, pending at k+2, int_b low after k+3.
  - Clear/mask writes at edge j: int_b high after j+1, unless another enabled source is still pending.
- int_b is a level signal. The CPU blocks nesting itself (isrv), so int_b simply stays low until software clears or masks the source. The ISR reads VECTOR, then W1Cs PENDING before RTI.
- Width rule: if NSRC < 16, unused MASK/MODE write bits are discarded.
- Reset at any time: all registers and synchroniser flops go to 0 and int_b goes to 1 immediately (asynchronously). A pending edge interrupt is lost.
- No other state; STATUS and VECTOR are purely combinational from pending and mask.

Test Plan:
- Reset, no activity -> int_b=1. Reads of offsets 0..7 return 0, except VECTOR=16'hFFFF; sel=1 only for address FE00..FE07.
- MASK=16'h0004, MODE=0, irq_src[2] raised at edge k -> int_b low after edge k+3; STATUS=16'h0004; VECTOR=16'h0002. Lower irq_src[2] -> int_b high 3 clocks later.
- MODE=16'h00FF, MASK=16'h00FF, 1-cycle pulses on src 5 and src 1 -> PENDING=16'h0022, VECTOR=1. W1C 16'h0002 -> VECTOR=5. W1C 16'h0020 -> int_b=1 next cycle.
- Edge src 3 pending; W1C bit 3 in the same cycle a new rising edge reaches s2/s3 detect -> PENDING bit 3 remains 1.
- Level src 0 held high, MASK=0 -> PENDING=1, STATUS=0, int_b=1. Write MASK=1 -> int_b low after the next edge. W1C on bit 0 -> no change.
- Assert reset_b=0 mid-cycle with int_b low -> int_b=1 and MASK=0 immediately. After release, pending edge interrupts are gone.

Source files
------------

// File: rtl/opc_intc.sv
// Prioritised, memory-mapped interrupt controller for the OPC5LS CPU.
// Each source can be masked and set to level or rising-edge mode; one active-low request goes to the CPU.
module opc_intc #(
  parameter int          NSRC      = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFE00
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic [15:0]     address,
  input  logic [15:0]     wdata,
  input  logic            rnw,
  input  logic [NSRC-1:0] irq_src,
  output logic [15:0]     rdata,
  output logic            sel,
  output logic            int_b
);

  logic [NSRC-1:0] s1, s2, s3;
  logic [NSRC-1:0] pending, mask, mode;
  logic [NSRC-1:0] clr, status, pending_next;
  logic [2:0]      offset;
  logic            wr;
  logic [15:0]     vector;
  logic            unused_wdata;

  assign sel    = (address[15:3] == BASE_ADDR[15:3]);
  assign offset = address[2:0];
  assign wr     = sel & ~rnw;
  assign status = pending & mask;

  // Only edge-mode bits can be cleared; level bits simply follow their input.
  assign clr = (wr && offset == 3'd2) ? (wdata[NSRC-1:0] & mode) : '0;

  // A fresh rising edge beats a simultaneous W1C.
  assign pending_next = (mode & ((s2 & ~s3) | (pending & ~clr))) | (~mode & s2);

  // Upper write-data bits are discarded when NSRC < 16.
  assign unused_wdata = &{1'b0, wdata};

  function automatic logic [15:0] pad(input logic [NSRC-1:0] v);
    pad = '0;
    pad[NSRC-1:0] = v;
  endfunction

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
    end else begin
      pending <= pending_next;
      if (wr && offset == 3'd1) mask <= wdata[NSRC-1:0];
      if (wr && offset == 3'd3) mode <= wdata[NSRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) int_b <= 1'b1;
    else          int_b <= ~(|status);
  end

  // Lowest-numbered enabled pending source wins.
  always_comb begin
    vector = 16'hFFFF;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (status[i]) vector = 16'(i);
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (sel) begin
      case (offset)
        3'd0:    rdata = pad(status);
        3'd1:    rdata = pad(mask);
        3'd2:    rdata = pad(pending);
        3'd3:    rdata = pad(mode);
        3'd4:    rdata = vector;
        default: rdata = 16'h0000;
      endcase
    end
  end

endmodule
